// File: rtl/caesar_mem_pkg.sv
// caesar_mem_pkg: shared enums and data/byte-enable widths for the CAESAR memory arbiter.
package caesar_mem_pkg;
  localparam int DataWidth = 32;
  localparam int BeWidth = DataWidth / 8;
  typedef enum logic [1:0] {ACTIVE, DRAIN, RETENTIVE, WAKE} state_e;
  typedef enum logic {PORT_BUS, PORT_ENG} port_e;
endpackage

// File: rtl/caesar_rr_arbiter.sv
// caesar_rr_arbiter: 2-way round-robin grant; the pointer names the port that wins the next contention.
module caesar_rr_arbiter
  import caesar_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  port_e ptr;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr <= PORT_BUS;
    else if (en && &req) ptr <= (ptr == PORT_BUS) ? PORT_ENG : PORT_BUS;
  end
  assign gnt[PORT_BUS] = en && req[PORT_BUS] && (!req[PORT_ENG] || ptr == PORT_BUS);
  assign gnt[PORT_ENG] = en && req[PORT_ENG] && (!req[PORT_BUS] || ptr == PORT_ENG);
endmodule

// File: rtl/caesar_mem_arbiter.sv
// caesar_mem_arbiter: arbitrates bus and engine ports onto one SRAM bank with retention sleep.
// Define CAESAR_MEM_ARB_STATS_EN to build the saturating contention counter on stall_cnt_o.
module caesar_mem_arbiter
  import caesar_mem_pkg::*;
#(
  parameter int NUM_WORDS = 1024,
  parameter int STALL_CNT_W = 16,
  localparam int AddrWidth = (NUM_WORDS <= 1) ? 1 : $clog2(NUM_WORDS)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   bus_req_i,
  input  logic                   bus_we_i,
  input  logic [AddrWidth-1:0]   bus_addr_i,
  input  logic [DataWidth-1:0]   bus_wdata_i,
  input  logic [BeWidth-1:0]     bus_be_i,
  output logic                   bus_gnt_o,
  output logic                   bus_rvalid_o,
  output logic [DataWidth-1:0]   bus_rdata_o,
  input  logic                   eng_req_i,
  input  logic                   eng_we_i,
  input  logic [AddrWidth-1:0]   eng_addr_i,
  input  logic [DataWidth-1:0]   eng_wdata_i,
  input  logic [BeWidth-1:0]     eng_be_i,
  output logic                   eng_gnt_o,
  output logic                   eng_rvalid_o,
  output logic [DataWidth-1:0]   eng_rdata_o,
  input  logic                   sleep_req_i,
  output logic                   sleep_ack_o,
  output logic                   mem_req_o,
  output logic                   mem_we_o,
  output logic [AddrWidth-1:0]   mem_addr_o,
  output logic [DataWidth-1:0]   mem_wdata_o,
  output logic [BeWidth-1:0]     mem_be_o,
  output logic                   mem_set_retentive_no,
  input  logic [DataWidth-1:0]   mem_rdata_i,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);
  state_e state, state_nx;
  logic en, pending, rd;
  logic [1:0] req, gnt;
  port_e owner;
  // Gating with rst_i keeps grants and mem_* low during the whole reset, not just after an edge.
  assign en = (state == ACTIVE) && !rst_i;
  assign req = {eng_req_i, bus_req_i};
  caesar_rr_arbiter u_arb (
    .clk(clk_i),
    .rst(rst_i),
    .en (en),
    .req(req),
    .gnt(gnt)
  );
  assign bus_gnt_o = gnt[PORT_BUS];
  assign eng_gnt_o = gnt[PORT_ENG];
  assign mem_req_o = |gnt;
  assign mem_we_o = gnt[PORT_ENG] ? eng_we_i : gnt[PORT_BUS] ? bus_we_i : 1'b0;
  assign mem_addr_o = gnt[PORT_ENG] ? eng_addr_i : gnt[PORT_BUS] ? bus_addr_i : '0;
  assign mem_wdata_o = gnt[PORT_ENG] ? eng_wdata_i : gnt[PORT_BUS] ? bus_wdata_i : '0;
  assign mem_be_o = gnt[PORT_ENG] ? eng_be_i : gnt[PORT_BUS] ? bus_be_i : '0;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ACTIVE;
      pending <= 1'b0;
      owner <= PORT_BUS;
      rd <= 1'b0;
    end else begin
      state <= state_nx;
      pending <= mem_req_o;
      owner <= gnt[PORT_ENG] ? PORT_ENG : PORT_BUS;
      rd <= !mem_we_o;
    end
  end
  always_comb begin
    state_nx = state;
    sleep_ack_o = 1'b0;
    mem_set_retentive_no = 1'b1;
    state_nx = (state == ACTIVE)    ? (sleep_req_i ? DRAIN : ACTIVE) :
               (state == DRAIN)     ? (!sleep_req_i ? ACTIVE : (pending ? DRAIN : RETENTIVE)) :
               (state == RETENTIVE) ? (sleep_req_i ? RETENTIVE : WAKE) : ACTIVE;
    sleep_ack_o = (state == RETENTIVE);
    mem_set_retentive_no = (state != RETENTIVE);
  end
  assign bus_rvalid_o = pending && owner == PORT_BUS;
  assign eng_rvalid_o = pending && owner == PORT_ENG;
  assign bus_rdata_o = (bus_rvalid_o && rd) ? mem_rdata_i : '0;
  assign eng_rdata_o = (eng_rvalid_o && rd) ? mem_rdata_i : '0;
`ifdef CAESAR_MEM_ARB_STATS_EN
  logic stall;
  assign stall = (bus_req_i && !bus_gnt_o) || (eng_req_i && !eng_gnt_o);
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) stall_cnt_o <= '0;
    else if (stall && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
  end
`else
  assign stall_cnt_o = '0;
`endif
endmodule

// File: tb/tb_caesar_mem_arbiter.sv
// tb_caesar_mem_arbiter: directed and random checks of the arbiter against a behavioural reference model.
module tb_caesar_mem_arbiter;
  localparam int PH_ACT = 0, PH_DRAIN = 1, PH_RET = 2, PH_WAKE = 3;
  localparam int SW = 4;
  logic clk_i = 1'b0, rst_i = 1'b1;
  logic bus_req_i = 0, bus_we_i = 0, eng_req_i = 0, eng_we_i = 0, sleep_req_i = 0;
  logic [9:0] bus_addr_i = '0, eng_addr_i = '0, mem_addr_o;
  logic [31:0] bus_wdata_i = '0, eng_wdata_i = '0, mem_wdata_o, mem_rdata_i, bus_rdata_o, eng_rdata_o;
  logic [3:0] bus_be_i = '0, eng_be_i = '0, mem_be_o;
  logic bus_gnt_o, bus_rvalid_o, eng_gnt_o, eng_rvalid_o, sleep_ack_o;
  logic mem_req_o, mem_we_o, mem_set_retentive_no;
  logic [SW-1:0] stall_cnt_o;
  int tests = 0, fails = 0;

  caesar_mem_arbiter #(.NUM_WORDS(1024), .STALL_CNT_W(SW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .bus_req_i(bus_req_i), .bus_we_i(bus_we_i), .bus_addr_i(bus_addr_i), .bus_wdata_i(bus_wdata_i),
    .bus_be_i(bus_be_i), .bus_gnt_o(bus_gnt_o), .bus_rvalid_o(bus_rvalid_o), .bus_rdata_o(bus_rdata_o),
    .eng_req_i(eng_req_i), .eng_we_i(eng_we_i), .eng_addr_i(eng_addr_i), .eng_wdata_i(eng_wdata_i),
    .eng_be_i(eng_be_i), .eng_gnt_o(eng_gnt_o), .eng_rvalid_o(eng_rvalid_o), .eng_rdata_o(eng_rdata_o),
    .sleep_req_i(sleep_req_i), .sleep_ack_o(sleep_ack_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_be_o(mem_be_o), .mem_set_retentive_no(mem_set_retentive_no), .mem_rdata_i(mem_rdata_i),
    .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] seed_word(int i);
    return (i * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  // SRAM stand-in: one-cycle read latency, byte-enabled writes.
  logic [31:0] sram [0:1023];
  logic [31:0] sram_q = '0;
  bit seeded = 0;
  assign mem_rdata_i = sram_q;
  always @(posedge clk_i) begin
    if (!seeded) begin
      for (int i = 0; i < 1024; i++) sram[i] <= seed_word(i);
      seeded <= 1;
    end else if (mem_req_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++) if (mem_be_o[b]) sram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      end else sram_q <= sram[mem_addr_o];
    end
  end

  typedef struct {int port; bit rd; logic [31:0] data;} resp_t;
  resp_t resp_q[$];
  logic [31:0] ref_mem [0:1023];
  int phase, turn, stall;

  task automatic model_reset();
    resp_q.delete();
    phase = PH_ACT;
    turn = 0;
    stall = 0;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    int win;
    bit act, had, ewe;
    logic [1:0] r;
    logic [9:0] ea;
    logic [31:0] ewd, es;
    logic [3:0] ebe;
    resp_t rsp;
    #1;
    r = {eng_req_i, bus_req_i};
    act = (phase == PH_ACT) && !rst_i;
    win = -1;
    if (act && r == 2'b11) win = turn;
    else if (act && r[0]) win = 0;
    else if (act && r[1]) win = 1;
    had = !rst_i && resp_q.size() > 0;
    rsp = had ? resp_q[0] : '{-1, 1'b0, 32'h0};
    ewe = (win == 0) ? bus_we_i : (win == 1) ? eng_we_i : 1'b0;
    ea = (win == 0) ? bus_addr_i : (win == 1) ? eng_addr_i : 10'h0;
    ewd = (win == 0) ? bus_wdata_i : (win == 1) ? eng_wdata_i : 32'h0;
    ebe = (win == 0) ? bus_be_i : (win == 1) ? eng_be_i : 4'h0;
`ifdef CAESAR_MEM_ARB_STATS_EN
    es = rst_i ? 0 : stall;
`else
    es = 0;
`endif
    chk("bus_gnt", bus_gnt_o, win == 0);
    chk("eng_gnt", eng_gnt_o, win == 1);
    chk("mem_req", mem_req_o, win >= 0);
    chk("mem_we", mem_we_o, ewe);
    chk("mem_addr", mem_addr_o, ea);
    chk("mem_wdata", mem_wdata_o, ewd);
    chk("mem_be", mem_be_o, ebe);
    chk("bus_rvalid", bus_rvalid_o, had && rsp.port == 0);
    chk("eng_rvalid", eng_rvalid_o, had && rsp.port == 1);
    chk("bus_rdata", bus_rdata_o, (had && rsp.port == 0 && rsp.rd) ? rsp.data : 32'h0);
    chk("eng_rdata", eng_rdata_o, (had && rsp.port == 1 && rsp.rd) ? rsp.data : 32'h0);
    chk("sleep_ack", sleep_ack_o, !rst_i && phase == PH_RET);
    chk("ret_no", mem_set_retentive_no, rst_i || phase != PH_RET);
    chk("stall_cnt", stall_cnt_o, es);
    @(posedge clk_i);
    #1;
    if (rst_i) model_reset();
    else begin
      if (had) void'(resp_q.pop_front());
      if (win >= 0) begin
        resp_q.push_back('{win, !ewe, ref_mem[ea]});
        if (ewe) for (int b = 0; b < 4; b++) if (ebe[b]) ref_mem[ea][8*b +: 8] = ewd[8*b +: 8];
      end
      if (act && r == 2'b11) turn = 1 - turn;
      if (((r[0] && win != 0) || (r[1] && win != 1)) && stall < (1 << SW) - 1) stall++;
      if (phase == PH_ACT) phase = sleep_req_i ? PH_DRAIN : PH_ACT;
      else if (phase == PH_DRAIN) phase = !sleep_req_i ? PH_ACT : had ? PH_DRAIN : PH_RET;
      else if (phase == PH_RET) phase = sleep_req_i ? PH_RET : PH_WAKE;
      else phase = PH_ACT;
    end
  endtask

  task automatic set_bus(logic req, logic we, logic [9:0] a, logic [31:0] d, logic [3:0] be);
    bus_req_i = req; bus_we_i = we; bus_addr_i = a; bus_wdata_i = d; bus_be_i = be;
  endtask

  task automatic set_eng(logic req, logic we, logic [9:0] a, logic [31:0] d, logic [3:0] be);
    eng_req_i = req; eng_we_i = we; eng_addr_i = a; eng_wdata_i = d; eng_be_i = be;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = seed_word(i);
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    // Reset state with a request pending: nothing may be granted.
    set_bus(1, 0, 10'h010, 0, 4'hF);
    cyc();
    rst_i = 0;
    // Bus-only read of 0x010.
    cyc();
    set_bus(0, 0, 0, 0, 0);
    #1;
    chk("req032_rdata", bus_rdata_o, seed_word('h010));
    cyc();
    // Contention after reset: bus, eng, bus, eng.
    rst_i = 1;
    cyc();
    rst_i = 0;
    set_bus(1, 0, 10'h001, 0, 4'hF);
    set_eng(1, 0, 10'h002, 0, 4'hF);
    repeat (4) cyc();
`ifdef CAESAR_MEM_ARB_STATS_EN
    chk("req033_stall", stall_cnt_o, 4);
`else
    chk("req033_stall", stall_cnt_o, 0);
`endif
    repeat (14) cyc();
`ifdef CAESAR_MEM_ARB_STATS_EN
    chk("stall_sat", stall_cnt_o, 15);
`else
    chk("stall_sat", stall_cnt_o, 0);
`endif
    // Engine write then read of the top word.
    set_bus(0, 0, 0, 0, 0);
    set_eng(1, 1, 10'h3FF, 32'hDEADBEEF, 4'hF);
    cyc();
    set_eng(1, 0, 10'h3FF, 0, 4'hF);
    cyc();
    set_eng(0, 0, 0, 0, 0);
    #1;
    chk("req034_rdata", eng_rdata_o, 32'hDEADBEEF);
    cyc();
    // Sleep requested in the grant cycle of a read.
    set_bus(1, 0, 10'h020, 0, 4'hF);
    sleep_req_i = 1;
    cyc();
    set_eng(1, 0, 10'h021, 0, 4'hF);
    repeat (3) cyc();
    chk("req035_ack", sleep_ack_o, 1);
    chk("req035_ret_no", mem_set_retentive_no, 0);
    cyc();
    // Wake: one grant-free cycle, then service resumes.
    sleep_req_i = 0;
    cyc();
    chk("req036_wake_gnt", mem_req_o, 0);
    chk("req036_wake_ret_no", mem_set_retentive_no, 1);
    cyc();
    chk("req036_active_gnt", mem_req_o, 1);
    cyc();
    set_bus(0, 0, 0, 0, 0);
    set_eng(0, 0, 0, 0, 0);
    cyc();
    // Reset asserted in the grant cycle of a read.
    set_bus(1, 0, 10'h030, 0, 4'hF);
    #1;
    chk("req037_gnt_before", bus_gnt_o, 1);
    rst_i = 1;
    #1;
    chk("req037_gnt_in_rst", bus_gnt_o, 0);
    chk("req037_mem_req_in_rst", mem_req_o, 0);
    @(posedge clk_i);
    #1;
    model_reset();
    rst_i = 0;
    set_bus(0, 0, 0, 0, 0);
    cyc();
    chk("req037_no_rvalid", bus_rvalid_o, 0);
    // Random traffic over a small address window, with sleep and reset pulses.
    for (int i = 0; i < 600; i++) begin
      rst_i = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 24) == 0) sleep_req_i = ~sleep_req_i;
      set_bus($urandom_range(0, 9) < 6, $urandom_range(0, 1), 10'h3F0 + 10'($urandom_range(0, 15)), $urandom, 4'($urandom));
      set_eng($urandom_range(0, 9) < 6, $urandom_range(0, 1), 10'h3F0 + 10'($urandom_range(0, 15)), $urandom, 4'($urandom));
      cyc();
    end
    rst_i = 0;
    sleep_req_i = 0;
    set_bus(0, 0, 0, 0, 0);
    set_eng(0, 0, 0, 0, 0);
    repeat (3) cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/caesar_mem_arbiter.md
CAESAR_MEM_ARBITER -- requirements
Module: caesar_mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 1024: words in the downstream SRAM bank.
REQ-002 SHALL have parameter STALL_CNT_W, default 16: width of the contention counter.
REQ-003 SHALL have localparam AddrWidth = clog2(NUM_WORDS), or 1 if NUM_WORDS <= 1; it is not overridable.
REQ-004 SHALL have port clk_i, input, 1: the only clock; all logic on its rising edge.
REQ-005 SHALL have port rst_i, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have ports bus_req_i/bus_we_i, input, 1/1: system-bus (OBI) request and write flag.
REQ-007 SHALL have ports bus_addr_i/bus_wdata_i/bus_be_i, input, AddrWidth/32/4: system-bus address, write data, byte enables.
REQ-008 SHALL have ports bus_gnt_o/bus_rvalid_o/bus_rdata_o, output, 1/1/32: system-bus grant, response valid, read data.
REQ-009 SHALL have ports eng_req_i, eng_we_i, eng_addr_i, eng_wdata_i, eng_be_i, eng_gnt_o, eng_rvalid_o, eng_rdata_o: the compute-engine port, same widths as bus_*.
REQ-010 SHALL have ports sleep_req_i/sleep_ack_o, input/output, 1/1: retention request and acknowledge.
REQ-011 SHALL have ports mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o, output, 1/1/AddrWidth/32/4: drive the SRAM wrapper.
REQ-012 SHALL have ports mem_set_retentive_no/mem_rdata_i, output/input, 1/32: SRAM retention control (active-low) and read data.
REQ-013 SHALL have port stall_cnt_o, output, STALL_CNT_W: contention statistic (see Configuration).

Function
REQ-014 SHALL grant at most one port per cycle: gnt is combinational from req in the same cycle, and only in state ACTIVE.
REQ-015 SHALL grant the only requester when one port requests; when both request, it SHALL grant round-robin, starting with bus after reset, then alternating after each contended grant.
REQ-016 SHALL drive mem_req_o = 1 exactly in cycles with a grant; mem_we_o/addr/wdata/be SHALL mux from the granted port, else hold 0.
REQ-017 SHALL assert rvalid for exactly one cycle, on the owning port, one cycle after each grant, for both reads and writes.
REQ-018 SHALL route rdata from mem_rdata_i to the owning port when it is a read response; otherwise rdata SHALL be 0.
REQ-019 SHALL track response ownership in one registered owner bit plus one pending flag.
REQ-020 SHALL implement the FSM ACTIVE -> DRAIN when sleep_req_i=1 (no grants from that cycle).
REQ-021 SHALL move DRAIN -> RETENTIVE when pending=0; sleep_ack_o SHALL be 1 and mem_set_retentive_no SHALL be 0 only in RETENTIVE.
REQ-022 SHALL move RETENTIVE -> WAKE when sleep_req_i=0; in WAKE, mem_set_retentive_no SHALL be 1 with no grants for one cycle, then ACTIVE.
REQ-023 SHALL return DRAIN -> ACTIVE, skipping retention, if sleep_req_i drops in DRAIN.
REQ-024 SHALL, on a read and write to the same address in consecutive cycles, apply them in grant order; no forwarding.

Reset
REQ-025 SHALL, while rst_i=1, hold FSM=ACTIVE, round-robin pointer=bus, pending=0, all gnt/rvalid/rdata/mem_* outputs=0, mem_set_retentive_no=1, sleep_ack_o=0, stall_cnt_o=0.
REQ-026 SHALL discard an in-flight response when reset asserts mid-transaction: no rvalid after reset release.

Configuration
REQ-027 SHALL use the macro CAESAR_MEM_ARB_STATS_EN.
REQ-028 SHALL, when the macro is defined, increment stall_cnt_o once per cycle in which a requesting port is not granted, saturating at all-ones.
REQ-029 SHALL, when the macro is undefined, tie stall_cnt_o to 0 with no counter flops.

Structure
REQ-030 SHALL place the FSM state enum (ACTIVE, DRAIN, RETENTIVE, WAKE), the port-index enum (PORT_BUS, PORT_ENG) and the data/BE width constants in package caesar_mem_pkg.
REQ-031 SHALL put 2-way round-robin grant logic and its pointer register in sub-module caesar_rr_arbiter.

Verification
REQ-032 Bus-only read: bus_req=1, we=0, addr=0x010 -> bus_gnt same cycle, mem_addr=0x010; next cycle bus_rvalid=1, bus_rdata=mem_rdata_i.
REQ-033 Contention: both req for 4 cycles after reset -> grants bus, eng, bus, eng; stall_cnt_o=4 with macro, 0 without.
REQ-034 Write then read: eng write 0xDEADBEEF, be=0xF, to 0x3FF, then read 0x3FF -> second rvalid returns 0xDEADBEEF.
REQ-035 Sleep with pending read: sleep_req_i=1 in grant cycle -> one rvalid, then RETENTIVE: sleep_ack_o=1, mem_set_retentive_no=0; reqs ignored.
REQ-036 Wake: drop sleep_req_i -> one WAKE cycle with no grant, then ACTIVE; next request granted.
REQ-037 Reset mid-read: rst_i=1 in the grant cycle -> all outputs 0, no rvalid after release.
